// File: rtl/reset_sequencer.sv
// reset_sequencer: synchronizes POR/soft reset and releases NUM_CH active-low resets in order.
module reset_sequencer #(
  parameter int NUM_CH      = 3,
  parameter int INIT_DELAY  = 16,
  parameter int STAGE_DELAY = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 8
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              soft_req,
  output logic [NUM_CH-1:0] porb,
  output logic [NUM_CH-1:0] por,
  output logic              done,
  output logic              busy
);
  localparam int MAX_A = INIT_DELAY > STAGE_DELAY ? INIT_DELAY : STAGE_DELAY;
  localparam int MAX_D = MAX_A > HOLD_CYCLES ? MAX_A : HOLD_CYCLES;
  localparam int CW    = $clog2(MAX_D + 1);
  typedef enum logic [1:0] {S_HOLD, S_WAIT, S_REL, S_DONE} state_t;
  logic [SYNC_STAGES-1:0] rst_sync_q, rst_sync_d, soft_sync_q, soft_sync_d;
  logic                   rst_n, soft_s;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [NUM_CH-1:0]      porb_q, porb_d, por_q;
  logic                   done_q, busy_q;
  always_comb begin
    rst_sync_d  = {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
    soft_sync_d = {soft_sync_q[SYNC_STAGES-2:0], soft_req};
  end
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) begin
      rst_sync_q  <= '0;
      soft_sync_q <= '0;
    end else begin
      rst_sync_q  <= rst_sync_d;
      soft_sync_q <= soft_sync_d;
    end
  assign rst_n  = rst_sync_q[SYNC_STAGES-1];
  assign soft_s = soft_sync_q[SYNC_STAGES-1];
  // porb shifts in ones from bit 0, so it stays thermometer-coded by construction
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    porb_d  = porb_q;
    if (soft_s) begin
      state_d = S_HOLD;
      cnt_d   = '0;
      porb_d  = '0;
    end else
      case (state_q)
        S_HOLD:
          if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        S_WAIT:
          if (cnt_q == CW'(INIT_DELAY - 1)) begin
            porb_d  = NUM_CH'(1);
            cnt_d   = '0;
            state_d = &porb_d ? S_DONE : S_REL;
          end
        S_REL:
          if (cnt_q == CW'(STAGE_DELAY - 1)) begin
            porb_d  = (porb_q << 1) | NUM_CH'(1);
            cnt_d   = '0;
            state_d = &porb_d ? S_DONE : S_REL;
          end
        default: cnt_d = '0;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_WAIT;
      cnt_q   <= '0;
      porb_q  <= '0;
      por_q   <= '1;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      porb_q  <= porb_d;
      por_q   <= ~porb_d;
      done_q  <= state_d == S_DONE;
      busy_q  <= state_d != S_DONE;
    end
  assign porb = porb_q;
  assign por  = por_q;
  assign done = done_q;
  assign busy = busy_q;
endmodule
